// File: rtl/ecc_decode_if.sv
// ecc_decode_if: bundles the read-side decoder's handshake and status signals.
//   slave  - decoder side: takes the FIFO word, check bits, out_ready and cnt_clr;
//            drives in_ready, the corrected word, flags, syndrome, counters and capture.
//   master - producer/consumer side, mirror image of slave.
interface ecc_decode_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ECC_WIDTH  = 6,
  parameter int unsigned CNT_WIDTH  = 16
);
  // Input side (FIFO read port)
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] DataIn;
  logic [ECC_WIDTH-1:0]  CorrIn;
  // Output side (consumer)
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] DataOut;
  logic                  err_single;
  logic                  err_double;
  logic [ECC_WIDTH-1:0]  syndrome;
  // Status / debug
  logic [CNT_WIDTH-1:0]  cnt_corr;
  logic [CNT_WIDTH-1:0]  cnt_uncorr;
  logic                  cnt_clr;
  logic [ECC_WIDTH-1:0]  first_syn;
  logic                  first_vld;

  modport slave (
    input  in_valid, DataIn, CorrIn, out_ready, cnt_clr,
    output in_ready, out_valid, DataOut, err_single, err_double, syndrome,
           cnt_corr, cnt_uncorr, first_syn, first_vld
  );

  modport master (
    output in_valid, DataIn, CorrIn, out_ready, cnt_clr,
    input  in_ready, out_valid, DataOut, err_single, err_double, syndrome,
           cnt_corr, cnt_uncorr, first_syn, first_vld
  );
endinterface

// File: rtl/ecc_decode.sv
// ecc_decode: read-side Hamming checker/corrector for 32-bit FIFO words.
//   Recomputes the 6 check bits (bit 0 = overall data parity, bits 5:1 = parity of data bits whose
//   index has the matching bit set), forms the syndrome, corrects single data-bit errors and flags
//   uncorrectable words. Two-stage valid/ready pipeline, saturating error counters and a sticky
//   first-error syndrome capture.
// Ports:
//   Clock - rising-edge clock
//   Reset - asynchronous, active-high; flushes the pipeline and clears all status
//   bus   - ecc_decode_if.slave: in_valid/in_ready/DataIn/CorrIn, out_valid/out_ready/DataOut,
//           err_single/err_double/syndrome, cnt_corr/cnt_uncorr/cnt_clr, first_syn/first_vld
module ecc_decode #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ECC_WIDTH  = 6,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input logic         Clock,
  input logic         Reset,
  ecc_decode_if.slave bus
);

  localparam int unsigned IdxW = ECC_WIDTH - 1;

  // Stage 1: raw data plus syndrome
  logic                  s1_v_q, s1_v_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic [ECC_WIDTH-1:0]  s1_syn_q, s1_syn_d;

  // Stage 2: corrected word and classification
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  err_single_q, err_single_d;
  logic                  err_double_q, err_double_d;
  logic [ECC_WIDTH-1:0]  syndrome_q, syndrome_d;

  // Status
  logic [CNT_WIDTH-1:0]  cnt_corr_q, cnt_corr_d;
  logic [CNT_WIDTH-1:0]  cnt_uncorr_q, cnt_uncorr_d;
  logic [ECC_WIDTH-1:0]  first_syn_q, first_syn_d;
  logic                  first_vld_q, first_vld_d;

  logic [ECC_WIDTH-1:0]  chk;
  logic [DATA_WIDTH-1:0] corr_data;
  logic [IdxW-1:0]       flip_idx;
  logic                  s2_en, s2_load, s1_en;
  logic                  is_single, is_double;

  // Check-bit recompute on the incoming word
  always_comb begin
    chk = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      chk[0] ^= bus.DataIn[i];
      for (int k = 1; k < ECC_WIDTH; k++) begin
        if (((i >> (k - 1)) & 1) != 0) begin
          chk[k] ^= bus.DataIn[i];
        end
      end
    end
  end

  // Pipeline advance: stage 2 takes a word when empty or draining; stage 1 when empty or its
  // word moves on. in_ready therefore depends on out_ready but never on the input word.
  assign s2_en   = !out_valid_q || bus.out_ready;
  assign s2_load = s2_en && s1_v_q;
  assign s1_en   = !s1_v_q || s2_en;

  // Odd syndrome means one flipped bit; its index sits in syndrome[5:1]. Syndrome 1 cannot be
  // told apart from a check-bit-0 error, so data bit 0 is flipped. Even non-zero syndromes
  // (including lone check-bit 1..5 errors) are reported as uncorrectable.
  assign is_single = s1_syn_q[0];
  assign is_double = !s1_syn_q[0] && (s1_syn_q != '0);
  assign flip_idx  = s1_syn_q[ECC_WIDTH-1:1];

  always_comb begin
    corr_data = s1_data_q;
    if (is_single) begin
      corr_data[flip_idx] = ~s1_data_q[flip_idx];
    end
  end

  // Stage 1 next state
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_data_d = s1_data_q;
    s1_syn_d  = s1_syn_q;
    if (s1_en) begin
      s1_v_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_data_d = bus.DataIn;
        s1_syn_d  = chk ^ bus.CorrIn;
      end
    end
  end

  // Stage 2 next state; payload only changes when a new word is loaded so outputs hold under
  // backpressure.
  always_comb begin
    out_valid_d  = out_valid_q;
    data_out_d   = data_out_q;
    err_single_d = err_single_q;
    err_double_d = err_double_q;
    syndrome_d   = syndrome_q;
    if (s2_en) begin
      out_valid_d = s1_v_q;
    end
    if (s2_load) begin
      data_out_d   = corr_data;
      err_single_d = is_single;
      err_double_d = is_double;
      syndrome_d   = s1_syn_q;
    end
  end

  // Counters and first-error capture update once per word on its load into stage 2.
  // A same-cycle clear wins and the word's event is dropped.
  always_comb begin
    cnt_corr_d   = cnt_corr_q;
    cnt_uncorr_d = cnt_uncorr_q;
    first_syn_d  = first_syn_q;
    first_vld_d  = first_vld_q;
    if (bus.cnt_clr) begin
      cnt_corr_d   = '0;
      cnt_uncorr_d = '0;
      first_syn_d  = '0;
      first_vld_d  = 1'b0;
    end else if (s2_load) begin
      if (is_single && (cnt_corr_q != '1)) begin
        cnt_corr_d = cnt_corr_q + CNT_WIDTH'(1);
      end
      if (is_double && (cnt_uncorr_q != '1)) begin
        cnt_uncorr_d = cnt_uncorr_q + CNT_WIDTH'(1);
      end
      if ((is_single || is_double) && !first_vld_q) begin
        first_syn_d = s1_syn_q;
        first_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s1_v_q       <= 1'b0;
      s1_data_q    <= '0;
      s1_syn_q     <= '0;
      out_valid_q  <= 1'b0;
      data_out_q   <= '0;
      err_single_q <= 1'b0;
      err_double_q <= 1'b0;
      syndrome_q   <= '0;
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
      first_syn_q  <= '0;
      first_vld_q  <= 1'b0;
    end else begin
      s1_v_q       <= s1_v_d;
      s1_data_q    <= s1_data_d;
      s1_syn_q     <= s1_syn_d;
      out_valid_q  <= out_valid_d;
      data_out_q   <= data_out_d;
      err_single_q <= err_single_d;
      err_double_q <= err_double_d;
      syndrome_q   <= syndrome_d;
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
      first_syn_q  <= first_syn_d;
      first_vld_q  <= first_vld_d;
    end
  end

  assign bus.in_ready   = s1_en;
  assign bus.out_valid  = out_valid_q;
  assign bus.DataOut    = data_out_q;
  assign bus.err_single = err_single_q;
  assign bus.err_double = err_double_q;
  assign bus.syndrome   = syndrome_q;
  assign bus.cnt_corr   = cnt_corr_q;
  assign bus.cnt_uncorr = cnt_uncorr_q;
  assign bus.first_syn  = first_syn_q;
  assign bus.first_vld  = first_vld_q;

endmodule

// File: tb/tb_ecc_decode.sv
// tb_ecc_decode: randomized and directed checks of ecc_decode against a behavioural model.
module tb_ecc_decode;

  localparam int DW = 32;
  localparam int EW = 6;
  localparam int CW = 16;
  localparam int CntMax = 65535;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ecc_decode_if #(.DATA_WIDTH(DW), .ECC_WIDTH(EW), .CNT_WIDTH(CW)) bus ();

  ecc_decode #(.DATA_WIDTH(DW), .ECC_WIDTH(EW), .CNT_WIDTH(CW)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        s;
    logic        d;
    logic [5:0]  syn;
  } exp_t;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  // Model of the status block
  int         m_corr = 0;
  int         m_uncorr = 0;
  logic [5:0] m_first = '0;
  logic       m_fvld = 1'b0;

  // Reference decode: counts set data bits per check group, then applies the classification rule.
  function automatic exp_t model(input logic [31:0] din, input logic [5:0] cin);
    exp_t e;
    logic [5:0] c;
    int n;
    int pos;
    c[0] = ($countones(din) % 2) == 1;
    for (int k = 1; k < 6; k++) begin
      n = 0;
      for (int i = 0; i < 32; i++) begin
        if (din[i] && ((i / (1 << (k - 1))) % 2 == 1)) n++;
      end
      c[k] = (n % 2) == 1;
    end
    e.syn  = c ^ cin;
    e.data = din;
    e.s    = 1'b0;
    e.d    = 1'b0;
    if (e.syn[0]) begin
      e.s = 1'b1;
      pos = int'(e.syn[5:1]);
      e.data[pos] = ~e.data[pos];
    end else if (e.syn != 6'h00) begin
      e.d = 1'b1;
    end
    return e;
  endfunction

  function automatic void note_word(input exp_t e);
    if (e.s && m_corr < CntMax) m_corr++;
    if (e.d && m_uncorr < CntMax) m_uncorr++;
    if ((e.s || e.d) && !m_fvld) begin
      m_fvld  = 1'b1;
      m_first = e.syn;
    end
  endfunction

  function automatic void model_clear();
    m_corr   = 0;
    m_uncorr = 0;
    m_first  = '0;
    m_fvld   = 1'b0;
  endfunction

  // Drive one cycle of inputs at the falling edge and report which handshakes the next rising
  // edge will complete.
  task automatic step(input logic iv, input logic [31:0] d, input logic [5:0] c,
                      input logic ordy, output logic in_hs, output logic out_hs);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.DataIn    = d;
    bus.CorrIn    = c;
    bus.out_ready = ordy;
    #1;
    in_hs  = iv && bus.in_ready;
    out_hs = bus.out_valid && ordy;
  endtask

  // Send one word with out_ready high; returns with the word on the output.
  task automatic send_one(input logic [31:0] d, input logic [5:0] c,
                          output logic acc, output logic early_v);
    logic ih, oh;
    step(1'b1, d, c, 1'b1, ih, oh);
    acc = ih;
    step(1'b0, 32'h0, 6'h00, 1'b1, ih, oh);
    early_v = bus.out_valid;
    step(1'b0, 32'h0, 6'h00, 1'b1, ih, oh);
    if (acc) note_word(model(d, c));
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.DataOut !== 32'h0 ||
        bus.err_single !== 1'b0 || bus.err_double !== 1'b0 || bus.syndrome !== 6'h00) begin
      failures++;
      $display("FAIL reset_outputs: got ov=%b ir=%b d=%h s=%b dbl=%b syn=%h want 0 1 0 0 0 0",
               bus.out_valid, bus.in_ready, bus.DataOut, bus.err_single, bus.err_double,
               bus.syndrome);
    end
    checks++;
    if (bus.cnt_corr !== 16'h0 || bus.cnt_uncorr !== 16'h0 || bus.first_syn !== 6'h00 ||
        bus.first_vld !== 1'b0) begin
      failures++;
      $display("FAIL reset_status: got cc=%h cu=%h fs=%h fv=%b want all 0",
               bus.cnt_corr, bus.cnt_uncorr, bus.first_syn, bus.first_vld);
    end
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_clean();
    logic acc, ev;
    send_one(32'hFFFF_FFFF, 6'h00, acc, ev);
    checks++;
    if (acc !== 1'b1 || ev !== 1'b0 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL clean_latency: got acc=%b early_v=%b ov=%b want 1 0 1", acc, ev,
               bus.out_valid);
    end
    checks++;
    if (bus.DataOut !== 32'hFFFF_FFFF || bus.err_single !== 1'b0 || bus.err_double !== 1'b0 ||
        bus.syndrome !== 6'h00) begin
      failures++;
      $display("FAIL clean_word: got d=%h s=%b dbl=%b syn=%h want ffffffff 0 0 00",
               bus.DataOut, bus.err_single, bus.err_double, bus.syndrome);
    end
  endtask

  task automatic test_single();
    logic acc, ev;
    send_one(32'hFFFF_FFDF, 6'h00, acc, ev);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.DataOut !== 32'hFFFF_FFFF || bus.err_single !== 1'b1 ||
        bus.err_double !== 1'b0 || bus.syndrome !== 6'h0B) begin
      failures++;
      $display("FAIL single_word: got ov=%b d=%h s=%b dbl=%b syn=%h want 1 ffffffff 1 0 0b",
               bus.out_valid, bus.DataOut, bus.err_single, bus.err_double, bus.syndrome);
    end
    checks++;
    if (bus.cnt_corr !== 16'd1 || bus.first_syn !== 6'h0B || bus.first_vld !== 1'b1) begin
      failures++;
      $display("FAIL single_status: got cc=%h fs=%h fv=%b want 0001 0b 1",
               bus.cnt_corr, bus.first_syn, bus.first_vld);
    end
  endtask

  task automatic test_double();
    logic acc, ev;
    send_one(32'hFFFF_FF9F, 6'h00, acc, ev);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.DataOut !== 32'hFFFF_FF9F || bus.err_single !== 1'b0 ||
        bus.err_double !== 1'b1 || bus.syndrome !== 6'h06) begin
      failures++;
      $display("FAIL double_word: got ov=%b d=%h s=%b dbl=%b syn=%h want 1 ffffff9f 0 1 06",
               bus.out_valid, bus.DataOut, bus.err_single, bus.err_double, bus.syndrome);
    end
    checks++;
    if (bus.cnt_uncorr !== 16'd1 || bus.cnt_corr !== 16'd1 || bus.first_syn !== 6'h0B ||
        bus.first_vld !== 1'b1) begin
      failures++;
      $display("FAIL double_status: got cu=%h cc=%h fs=%h fv=%b want 0001 0001 0b 1",
               bus.cnt_uncorr, bus.cnt_corr, bus.first_syn, bus.first_vld);
    end
  endtask

  task automatic test_clear();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.cnt_clr  = 1'b1;
    @(negedge clk);
    bus.cnt_clr = 1'b0;
    #1;
    model_clear();
    checks++;
    if (bus.cnt_corr !== 16'h0 || bus.cnt_uncorr !== 16'h0 || bus.first_syn !== 6'h00 ||
        bus.first_vld !== 1'b0) begin
      failures++;
      $display("FAIL clear_idle: got cc=%h cu=%h fs=%h fv=%b want all 0",
               bus.cnt_corr, bus.cnt_uncorr, bus.first_syn, bus.first_vld);
    end
  endtask

  // Stream n random words (clean, 1 or 2 data-bit errors, or a check-bit error). bp selects the
  // fixed stall window (out_ready low in stream cycles 3..6) instead of random out_ready.
  task automatic run_stream(input int n, input bit bp, output int got, output bit saw_stall);
    exp_t e, q;
    logic ih, oh, iv, ordy, have, prev_stall;
    logic [31:0] d, pd;
    logic [5:0] c, psyn;
    logic ps, pdb;
    int sent, cyc, kind, b1, b2;
    sent = 0; got = 0; cyc = 0; have = 1'b0; prev_stall = 1'b0; saw_stall = 1'b0;
    d = '0; c = '0; pd = '0; psyn = '0; ps = 1'b0; pdb = 1'b0;
    exp_q.delete();
    while ((sent < n || exp_q.size() != 0) && cyc < 5000) begin
      if (!have && sent < n) begin
        d = $urandom;
        c = model(d, 6'h00).syn;
        kind = $urandom_range(0, 3);
        b1 = $urandom_range(0, 31);
        b2 = (b1 + $urandom_range(1, 31)) % 32;
        case (kind)
          1: d[b1] = ~d[b1];
          2: begin d[b1] = ~d[b1]; d[b2] = ~d[b2]; end
          3: c[$urandom_range(0, 5)] ^= 1'b1;
          default: ;
        endcase
        have = 1'b1;
      end
      iv = have;
      ordy = bp ? !(cyc >= 3 && cyc <= 6) : ($urandom_range(0, 3) != 0);
      step(iv, d, c, ordy, ih, oh);
      if (iv && !bus.in_ready) saw_stall = 1'b1;
      if (prev_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.DataOut !== pd || bus.err_single !== ps ||
            bus.err_double !== pdb || bus.syndrome !== psyn) begin
          failures++;
          $display("FAIL hold_stable: got ov=%b d=%h s=%b dbl=%b syn=%h want 1 %h %b %b %h",
                   bus.out_valid, bus.DataOut, bus.err_single, bus.err_double, bus.syndrome,
                   pd, ps, pdb, psyn);
        end
      end
      if (oh) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_word: got d=%h want no word", bus.DataOut);
        end else begin
          q = exp_q.pop_front();
          got++;
          if (bus.DataOut !== q.data || bus.err_single !== q.s || bus.err_double !== q.d ||
              bus.syndrome !== q.syn) begin
            failures++;
            $display("FAIL stream_word: got d=%h s=%b dbl=%b syn=%h want %h %b %b %h",
                     bus.DataOut, bus.err_single, bus.err_double, bus.syndrome,
                     q.data, q.s, q.d, q.syn);
          end
        end
      end
      if (ih) begin
        e = model(d, c);
        exp_q.push_back(e);
        note_word(e);
        sent++;
        have = 1'b0;
      end
      prev_stall = bus.out_valid && !ordy;
      pd = bus.DataOut; ps = bus.err_single; pdb = bus.err_double; psyn = bus.syndrome;
      cyc++;
    end
    checks++;
    if (cyc >= 5000) begin
      failures++;
      $display("FAIL stream_timeout: got sent=%0d delivered=%0d want %0d", sent, got, n);
    end
  endtask

  task automatic test_back_to_back();
    int got;
    bit stall;
    run_stream(8, 1'b1, got, stall);
    checks++;
    if (got !== 8 || stall !== 1'b1) begin
      failures++;
      $display("FAIL backpressure: got delivered=%0d in_ready_low=%b want 8 1", got, stall);
    end
  endtask

  task automatic test_random();
    int got;
    bit stall;
    run_stream(300, 1'b0, got, stall);
    checks++;
    if (got !== 300) begin
      failures++;
      $display("FAIL random_count: got %0d want 300", got);
    end
    checks++;
    if (bus.cnt_corr !== 16'(m_corr) || bus.cnt_uncorr !== 16'(m_uncorr) ||
        bus.first_syn !== m_first || bus.first_vld !== m_fvld) begin
      failures++;
      $display("FAIL random_status: got cc=%h cu=%h fs=%h fv=%b want %h %h %h %b",
               bus.cnt_corr, bus.cnt_uncorr, bus.first_syn, bus.first_vld,
               16'(m_corr), 16'(m_uncorr), m_first, m_fvld);
    end
  endtask

  task automatic test_saturate();
    logic ih, oh;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    while ((sent < 65540 || got < sent) && cyc < 70000) begin
      step(sent < 65540, 32'hFFFF_FFDF, 6'h00, 1'b1, ih, oh);
      if (oh) got++;
      if (ih) begin
        note_word(model(32'hFFFF_FFDF, 6'h00));
        sent++;
      end
      cyc++;
    end
    step(1'b0, 32'h0, 6'h00, 1'b1, ih, oh);
    checks++;
    if (got !== 65540) begin
      failures++;
      $display("FAIL saturate_count: got %0d want 65540", got);
    end
    checks++;
    if (bus.cnt_corr !== 16'(m_corr) || bus.cnt_uncorr !== 16'(m_uncorr) ||
        bus.first_syn !== m_first) begin
      failures++;
      $display("FAIL saturate_status: got cc=%h cu=%h fs=%h want %h %h %h", bus.cnt_corr,
               bus.cnt_uncorr, bus.first_syn, 16'(m_corr), 16'(m_uncorr), m_first);
    end
  endtask

  // Error word reaches stage 2 on the same edge that cnt_clr is sampled.
  task automatic test_clear_collision();
    logic ih, oh;
    step(1'b1, 32'hFFFF_FFDF, 6'h00, 1'b1, ih, oh);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.cnt_clr  = 1'b1;
    @(negedge clk);
    bus.cnt_clr = 1'b0;
    #1;
    model_clear();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.err_single !== 1'b1 || bus.DataOut !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL collision_word: got ov=%b s=%b d=%h want 1 1 ffffffff",
               bus.out_valid, bus.err_single, bus.DataOut);
    end
    checks++;
    if (bus.cnt_corr !== 16'h0 || bus.cnt_uncorr !== 16'h0 || bus.first_vld !== 1'b0 ||
        bus.first_syn !== 6'h00) begin
      failures++;
      $display("FAIL collision_status: got cc=%h cu=%h fv=%b fs=%h want 0 0 0 00",
               bus.cnt_corr, bus.cnt_uncorr, bus.first_vld, bus.first_syn);
    end
    step(1'b0, 32'h0, 6'h00, 1'b1, ih, oh);
  endtask

  task automatic test_reset_inflight();
    logic ih, oh, acc, ev;
    step(1'b1, 32'hFFFF_FFDF, 6'h00, 1'b0, ih, oh);
    step(1'b1, 32'hFFFF_FF9F, 6'h00, 1'b0, ih, oh);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.cnt_corr !== 16'd1) begin
      failures++;
      $display("FAIL inflight_setup: got ov=%b ir=%b cc=%h want 1 0 0001",
               bus.out_valid, bus.in_ready, bus.cnt_corr);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.DataOut !== 32'h0 ||
        bus.cnt_corr !== 16'h0 || bus.cnt_uncorr !== 16'h0 || bus.first_vld !== 1'b0) begin
      failures++;
      $display("FAIL inflight_reset: got ov=%b ir=%b d=%h cc=%h cu=%h fv=%b want 0 1 0 0 0 0",
               bus.out_valid, bus.in_ready, bus.DataOut, bus.cnt_corr, bus.cnt_uncorr,
               bus.first_vld);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    model_clear();
    send_one(32'hFFFF_FFFE, 6'h00, acc, ev);
    checks++;
    if (acc !== 1'b1 || ev !== 1'b0 || bus.out_valid !== 1'b1 ||
        bus.DataOut !== 32'hFFFF_FFFF || bus.err_single !== 1'b1 || bus.syndrome !== 6'h01 ||
        bus.cnt_corr !== 16'd1) begin
      failures++;
      $display("FAIL post_reset_word: got acc=%b ev=%b ov=%b d=%h s=%b syn=%h cc=%h want 1 0 1 ffffffff 1 01 0001",
               acc, ev, bus.out_valid, bus.DataOut, bus.err_single, bus.syndrome, bus.cnt_corr);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.DataIn    = '0;
    bus.CorrIn    = '0;
    bus.out_ready = 1'b0;
    bus.cnt_clr   = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_clear();
    test_random();
    test_back_to_back();
    test_saturate();
    test_clear_collision();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion want finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
